// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Reads a programmable address range {base, len} from a single-port SRAM and
// streams the words out over valid/ready. The SRAM has a 1-cycle read latency.
// Read data lands in a small first-word-fall-through prefetch FIFO.
// FIFO space is reserved when a read is issued, so back-pressure can never
// cause a returning word to be dropped.
// Loop mode repeats the range until i_stop is asserted.
module mem_stream_reader #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_stop,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_mem_csb,
  output logic              o_mem_web,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  // Latched command and pass progress
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic              mode_q;
  logic [ADDR_W-1:0] cur_q;
  logic [LEN_W-1:0]  issued_q;

  // Read pipeline and completion bookkeeping
  logic              inflight_q;
  logic              empty_done_q;
  logic              issue;
  logic              drain_done;

  // Prefetch FIFO
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  fifo_count_q;
  logic              push;
  logic              pop;

  logic              accept_cmd;
  logic              empty_cmd;
  logic              last_of_pass;
  logic [OCC_W-1:0]  occupancy;

  assign accept_cmd   = (state_q == S_IDLE) && i_start && (i_len != '0);
  assign empty_cmd    = (state_q == S_IDLE) && i_start && (i_len == '0);
  assign last_of_pass = (issued_q == len_q - LEN_W'(1));

  // Buffered words plus the word still coming back from the SRAM.
  // This total must stay below the depth before another read may be issued.
  assign occupancy    = {1'b0, fifo_count_q} + OCC_W'(inflight_q);

  assign push         = inflight_q;
  assign pop          = o_valid && i_ready;

  assign o_valid      = (fifo_count_q != '0);
  assign o_data       = o_valid ? fifo_mem[rd_ptr_q] : '0;
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = drain_done || empty_done_q;
  assign o_mem_csb    = ~issue;
  assign o_mem_web    = 1'b1;
  assign o_mem_addr   = cur_q;

  // State register
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values; blocking here creates order-dependent simulation races.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, read issue and drain completion
  // NOTE: every output of this block is given a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_cmd) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          state_d = S_DRAIN;
        end else if (occupancy < DEPTH_OCC) begin
          issue = 1'b1;
          if (last_of_pass && !mode_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((fifo_count_q == '0) && !inflight_q) begin
          drain_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, address walk and in-flight tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      base_q       <= '0;
      len_q        <= '0;
      mode_q       <= 1'b0;
      cur_q        <= '0;
      issued_q     <= '0;
      inflight_q   <= 1'b0;
      empty_done_q <= 1'b0;
    end else begin
      empty_done_q <= empty_cmd;
      inflight_q   <= issue;
      if (accept_cmd) begin
        base_q   <= i_base;
        len_q    <= i_len;
        mode_q   <= i_mode;
        cur_q    <= i_base;
        issued_q <= '0;
      end else if (issue) begin
        if (last_of_pass) begin
          // Rewind for the next pass; unused when a single pass ends here
          cur_q    <= base_q;
          issued_q <= '0;
        end else begin
          cur_q    <= cur_q + ADDR_W'(1);
          issued_q <= issued_q + LEN_W'(1);
        end
      end
    end
  end

  // FIFO pointers and fill count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // FIFO storage: capture the SRAM word the cycle after its read was issued
  // NOTE: storage array is deliberately not reset; the count/pointers define which entries are valid, and o_data is gated when empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader.
// The bench models the SRAM with a 1-cycle read.
// A monitor captures accepted words and issued addresses.
// A reference model derives the expected stream from {base, len} alone:
// word i comes from address (base + i mod len) mod 256.
module tb_mem_stream_reader;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BUDGET     = 1000;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic       i_mode;
  logic [7:0] i_base;
  logic [8:0] i_len;
  logic       i_stop;
  logic       i_ready = 1'b0;
  logic       o_busy;
  logic       o_done;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_mem_csb;
  logic       o_mem_web;
  logic [7:0] o_mem_addr;
  logic [7:0] i_mem_rdata = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  logic [7:0] mem [256];
  logic [7:0] got[$];
  logic [7:0] addrs[$];
  int         stab_err = 0;
  int         occ_err  = 0;
  int         web_err  = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  mem_stream_reader #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_base     (i_base),
    .i_len      (i_len),
    .i_stop     (i_stop),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_mem_csb  (o_mem_csb),
    .o_mem_web  (o_mem_web),
    .o_mem_addr (o_mem_addr),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: data valid the cycle after csb=0, garbage otherwise
  always @(posedge clk) begin
    if (!o_mem_csb) i_mem_rdata <= mem[o_mem_addr];
    else            i_mem_rdata <= 8'($urandom);
  end

  // Sink ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = ($urandom_range(0, 99) < 60);
      default: i_ready = 1'b0;
    endcase
  end

  // Monitor: accepted words, issued reads, hold stability, occupancy bound
  always @(negedge clk) begin
    if (i_reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!o_valid || (o_data !== prev_data))) stab_err++;
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
      if (o_valid && i_ready) got.push_back(o_data);
      if (!o_mem_csb) addrs.push_back(o_mem_addr);
      if (addrs.size() > got.size() + FIFO_DEPTH) occ_err++;
    end
    if (o_mem_web !== 1'b1) web_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [7:0] model_addr(input logic [7:0] base, input logic [8:0] len, input int idx);
    int off;
    off = idx % int'(len);
    return 8'((int'(base) + off) % 256);
  endfunction

  function automatic logic [7:0] model_word(input logic [7:0] base, input logic [8:0] len, input int idx);
    return mem[model_addr(base, len, idx)];
  endfunction

  // Wait for completion (optionally requesting stop), then compare against the model
  task automatic finish_cmd(input string name, input logic [7:0] base, input logic [8:0] len,
                            input logic mode, input int stop_after);
    int cycles   = 0;
    bit done_seen = 1'b0;
    bit stop_pending = 1'b0;
    int word_err = 0;
    int addr_err = 0;
    int lo, hi;
    while (!done_seen && cycles < BUDGET) begin
      @(posedge clk); #1;
      if (stop_pending) i_stop = 1'b1;
      @(negedge clk); #1;
      cycles++;
      if (o_done) done_seen = 1'b1;
      else if (stop_after >= 0 && got.size() >= stop_after) stop_pending = 1'b1;
    end
    check({name, "/done_seen"}, 32'(done_seen), 32'd1);
    @(posedge clk); #1;
    i_stop = 1'b0;
    @(negedge clk); #1;
    check({name, "/idle_after_done"}, {30'd0, o_busy, o_done}, 32'd0);
    if (stop_after < 0) begin
      lo = int'(len);
      hi = int'(len);
    end else if (mode) begin
      lo = stop_after;
      hi = stop_after + FIFO_DEPTH;
    end else begin
      lo = (stop_after < int'(len)) ? stop_after : int'(len);
      hi = (stop_after + FIFO_DEPTH < int'(len)) ? stop_after + FIFO_DEPTH : int'(len);
    end
    check_range({name, "/word_count"}, got.size(), lo, hi);
    check({name, "/issued_vs_delivered"}, 32'(addrs.size()), 32'(got.size()));
    foreach (got[i]) if (got[i] !== model_word(base, len, i)) word_err++;
    foreach (addrs[i]) if (addrs[i] !== model_addr(base, len, i)) addr_err++;
    check({name, "/data_order"}, 32'(word_err), 32'd0);
    check({name, "/addr_order"}, 32'(addr_err), 32'd0);
  endtask

  task automatic start_cmd(input logic [7:0] base, input logic [8:0] len, input logic mode);
    got.delete();
    addrs.delete();
    @(posedge clk); #1;
    i_start = 1'b1;
    i_base  = base;
    i_len   = len;
    i_mode  = mode;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_base  = 8'($urandom);
    i_len   = 9'($urandom);
    i_mode  = 1'($urandom);
  endtask

  task automatic run_cmd(input string name, input logic [7:0] base, input logic [8:0] len,
                         input logic mode, input int stop_after, input int rmode);
    ready_mode = rmode;
    start_cmd(base, len, mode);
    finish_cmd(name, base, len, mode, stop_after);
  endtask

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       csb;
    logic       done;
    logic       busy;
  } cyc_t;

  typedef struct {
    logic [7:0] base;
    logic [8:0] len;
    int         rmode;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  cyc_t lat_tab[8];
  vec_t vecs[6];

  initial begin
    // Expected per-cycle outputs after i_start (cycle 0): base=0x10, len=4, ready=1
    lat_tab[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    lat_tab[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    lat_tab[2] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1};
    lat_tab[3] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1};
    lat_tab[4] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b1};
    lat_tab[5] = '{1'b1, 8'h13, 1'b1, 1'b0, 1'b1};
    lat_tab[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    lat_tab[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

    // Single-pass commands over mem[a]=a
    vecs[0] = '{8'h10, 9'd4,   0, 8'h10, 8'h13};
    vecs[1] = '{8'hFE, 9'd4,   0, 8'hFE, 8'h01};
    vecs[2] = '{8'hFF, 9'd2,   1, 8'hFF, 8'h00};
    vecs[3] = '{8'h80, 9'd1,   1, 8'h80, 8'h80};
    vecs[4] = '{8'h00, 9'd256, 0, 8'h00, 8'hFF};
    vecs[5] = '{8'hF0, 9'd20,  1, 8'hF0, 8'h03};

    i_reset = 1'b1;
    i_start = 1'b0;
    i_mode  = 1'b0;
    i_base  = 8'h00;
    i_len   = 9'd0;
    i_stop  = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/busy",  32'(o_busy),     32'd0);
    check("rst/done",  32'(o_done),     32'd0);
    check("rst/valid", 32'(o_valid),    32'd0);
    check("rst/data",  32'(o_data),     32'd0);
    check("rst/csb",   32'(o_mem_csb),  32'd1);
    check("rst/web",   32'(o_mem_web),  32'd1);
    check("rst/addr",  32'(o_mem_addr), 32'd0);
    @(posedge clk); #1;
    i_reset = 1'b0;

    // Cycle-exact latency and drain timing
    ready_mode = 0;
    got.delete();
    addrs.delete();
    @(posedge clk); #1;
    i_start = 1'b1;
    i_base  = 8'h10;
    i_len   = 9'd4;
    i_mode  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      check($sformatf("lat%0d/valid", k + 1), 32'(o_valid),   32'(lat_tab[k].valid));
      check($sformatf("lat%0d/csb", k + 1),   32'(o_mem_csb), 32'(lat_tab[k].csb));
      check($sformatf("lat%0d/done", k + 1),  32'(o_done),    32'(lat_tab[k].done));
      check($sformatf("lat%0d/busy", k + 1),  32'(o_busy),    32'(lat_tab[k].busy));
      if (lat_tab[k].valid) check($sformatf("lat%0d/data", k + 1), 32'(o_data), 32'(lat_tab[k].data));
    end
    check("lat/first_addr", 32'(addrs[0]), 32'h10);

    // Table-driven single-pass commands, including wrap and full-memory range
    for (int v = 0; v < 6; v++) begin
      run_cmd($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, 1'b0, -1, vecs[v].rmode);
      check($sformatf("vec%0d/nonempty", v), 32'(got.size() != 0), 32'd1);
      if (got.size() != 0) begin
        check($sformatf("vec%0d/first", v), 32'(got[0]), 32'(vecs[v].exp_first));
        check($sformatf("vec%0d/last", v),  32'(got[got.size() - 1]), 32'(vecs[v].exp_last));
      end
    end

    // Back-pressure: sink stalled for 20 cycles, then drains without loss
    ready_mode = 2;
    start_cmd(8'h40, 9'd8, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    check("bp/issued_while_stalled", 32'(addrs.size()), 32'd4);
    check("bp/none_delivered",       32'(got.size()),   32'd0);
    check("bp/valid_held",           32'(o_valid),      32'd1);
    check("bp/csb_idle",             32'(o_mem_csb),    32'd1);
    check("bp/busy",                 32'(o_busy),       32'd1);
    ready_mode = 0;
    finish_cmd("bp", 8'h40, 9'd8, 1'b0, -1);

    // Loop mode, stop after 7 accepted words
    run_cmd("loop", 8'h20, 9'd3, 1'b1, 7, 0);

    // Empty command: done pulse next cycle, no SRAM access
    got.delete();
    addrs.delete();
    @(posedge clk); #1;
    i_start = 1'b1;
    i_base  = 8'h33;
    i_len   = 9'd0;
    i_mode  = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk); #1;
    check("len0/done",  32'(o_done), 32'd1);
    check("len0/busy",  32'(o_busy), 32'd0);
    @(negedge clk); #1;
    check("len0/done_once", 32'(o_done), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("len0/no_access", 32'(addrs.size()), 32'd0);

    // Start while busy is ignored; the latched command runs unchanged
    ready_mode = 1;
    start_cmd(8'h50, 9'd6, 1'b0);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_base  = 8'h90;
    i_len   = 9'd2;
    i_mode  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    finish_cmd("busy_start", 8'h50, 9'd6, 1'b0, -1);
    repeat (4) @(negedge clk);
    #1;
    check("busy_start/no_restart", 32'(addrs.size()), 32'd6);
    check("busy_start/idle",       32'(o_busy),       32'd0);

    // Reset mid-RUN with 3 words buffered and one read in flight
    ready_mode = 2;
    start_cmd(8'h30, 9'd8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(negedge clk); #1;
    check("midrst/buffered_valid", 32'(o_valid),      32'd1);
    check("midrst/reads_issued",   32'(addrs.size()), 32'd4);
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk); #1;
    check("midrst/valid", 32'(o_valid),   32'd0);
    check("midrst/csb",   32'(o_mem_csb), 32'd1);
    check("midrst/busy",  32'(o_busy),    32'd0);
    check("midrst/done",  32'(o_done),    32'd0);
    run_cmd("after_rst", 8'h60, 9'd5, 1'b0, -1, 1);

    // Randomized commands against the reference model
    for (int r = 0; r < 20; r++) begin
      logic [7:0] rb;
      logic [8:0] rl;
      logic       rm;
      int         rs;
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      rb = 8'($urandom);
      rl = 9'($urandom_range(1, 40));
      rm = 1'($urandom_range(0, 1));
      if (rm) rs = $urandom_range(0, 30);
      else    rs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rl)) : -1;
      run_cmd($sformatf("rnd%0d", r), rb, rl, rm, rs, $urandom_range(0, 1));
    end

    check("global/hold_stable",   32'(stab_err), 32'd0);
    check("global/fifo_bound",    32'(occ_err),  32'd0);
    check("global/web_high",      32'(web_err),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
